// File: rtl/pipe_pkg.sv
// Shared types for the fetch-side pipeline control: sequencer states,
// redirect-source codes and the sequential next-PC helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PEND
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_TRAP,
        SRC_BR,
        SRC_JMP
    } src_e;

    localparam int unsigned INSN_BYTES = 4;

    // Wraps modulo 2^32, so the last word of the address space falls through to 0.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'(INSN_BYTES);
    endfunction

endpackage

// File: rtl/pc_sequencer_redirect_prio.sv
// Fixed-priority redirect select: trap > EX branch > ID jump.
// Purely combinational; shared by the direct and pending-capture paths.
module redirect_prio
    import pipe_pkg::*;
(
    input  logic        trap,
    input  logic [31:0] trap_vec,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output src_e        src,
    output logic [31:0] target
);

    always_comb begin
        src    = SRC_NONE;
        target = '0;
        if (trap) begin
            src    = SRC_TRAP;
            target = trap_vec;
        end else if (br_taken) begin
            src    = SRC_BR;
            target = br_target;
        end else if (jmp) begin
            src    = SRC_JMP;
            target = jmp_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot hold, redirect priority, load-use bubbles,
// redirect buffering across memory stalls, and saturating event counters.
module pc_sequencer
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BOOT_CYCLES  = 4,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_cur,
    input  logic             mem_busy,
    input  logic             ld_use,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp,
    input  logic [31:0]      jmp_target,
    input  logic             trap,
    input  logic [31:0]      trap_vec,
    output logic [31:0]      npc,
    output logic             pc_stop,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic              pend_valid_q, pend_valid_d;
    logic [31:0]       pend_target_q, pend_target_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    src_e        sel_src;
    logic [31:0] sel_target;
    logic        stall_evt;
    logic        redirect_evt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    redirect_prio u_prio (
        .trap       (trap),
        .trap_vec   (trap_vec),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .src        (sel_src),
        .target     (sel_target)
    );

    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        npc           = pc_cur;
        pc_stop       = 1'b1;
        stall_if_id   = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        stall_evt     = 1'b0;
        redirect_evt  = 1'b0;

        // Outputs stay in their safe hold values for the whole reset cycle.
        if (!rst) begin
            case (state_q)
                BOOT: begin
                    if (boot_cnt_q == BOOT_LAST) begin
                        npc     = RESET_VECTOR;
                        pc_stop = 1'b0;
                        state_d = RUN;
                    end else begin
                        boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                    end
                end

                RUN: begin
                    if (mem_busy) begin
                        stall_if_id = 1'b1;
                        stall_evt   = 1'b1;
                        if (sel_src != SRC_NONE) begin
                            pend_valid_d  = 1'b1;
                            pend_target_d = sel_target;
                            state_d       = PEND;
                        end
                    end else if (sel_src == SRC_TRAP || sel_src == SRC_BR) begin
                        // Squashes the instruction in ID, so a load-use stall is moot.
                        npc          = sel_target;
                        pc_stop      = 1'b0;
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        redirect_evt = 1'b1;
                    end else if (ld_use) begin
                        // A jump in ID is re-presented once the bubble clears.
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        stall_evt   = 1'b1;
                    end else if (sel_src == SRC_JMP) begin
                        npc          = sel_target;
                        pc_stop      = 1'b0;
                        flush_if_id  = 1'b1;
                        redirect_evt = 1'b1;
                    end else begin
                        npc     = seq_pc(pc_cur);
                        pc_stop = 1'b0;
                    end
                end

                PEND: begin
                    if (!pend_valid_q) begin
                        state_d = RUN;
                    end else if (mem_busy) begin
                        stall_if_id = 1'b1;
                        stall_evt   = 1'b1;
                        if (sel_src == SRC_TRAP) begin
                            pend_target_d = sel_target;
                        end
                    end else begin
                        npc          = (sel_src == SRC_TRAP) ? sel_target : pend_target_q;
                        pc_stop      = 1'b0;
                        flush_if_id  = 1'b1;
                        flush_id_ex  = 1'b1;
                        redirect_evt = 1'b1;
                        pend_valid_d = 1'b0;
                        state_d      = RUN;
                    end
                end

                default: state_d = BOOT;
            endcase

            if (stall_evt) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
            if (redirect_evt) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            boot_cnt_q    <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
